// File: rtl/vending_pkg.sv
// Shared encodings for the vending_credit slice: FSM states, coin codes and
// the parameter legality check used at elaboration.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_2    = 2'd2;
    localparam logic [1:0] COIN_3    = 2'd3;

    // Every amount must be a nonzero multiple of the change unit, and the
    // largest credit reachable (one unit short of the price plus the biggest
    // coin) must fit in the credit register.
    function automatic bit params_legal(input int price, input int c1, input int c2,
                                        input int c3, input int unit, input int width);
        int max_coin;
        bit ok;
        max_coin = (c1 > c2) ? c1 : c2;
        max_coin = (c3 > max_coin) ? c3 : max_coin;
        ok = (unit > 0) && (price > 0) && (c1 > 0) && (c2 > 0) && (c3 > 0);
        if (ok) begin
            ok = ((price % unit) == 0) && ((c1 % unit) == 0) &&
                 ((c2 % unit) == 0) && ((c3 % unit) == 0);
            ok = ok && ((price - unit + max_coin) < (1 << width));
        end
        return ok;
    endfunction

endpackage

// File: rtl/coin_value_dec.sv
// Combinational coin-code to money-value decoder for the vending_credit slice.
module coin_value_dec
    import vending_pkg::*;
#(
    parameter int CREDIT_W  = 6,
    parameter int COIN1_VAL = 5,
    parameter int COIN2_VAL = 10,
    parameter int COIN3_VAL = 25
) (
    input  logic [1:0]          i_coin,
    output logic [CREDIT_W-1:0] o_value
);

    always_comb begin
        o_value = '0;
        case (i_coin)
            COIN_1:  o_value = CREDIT_W'(COIN1_VAL);
            COIN_2:  o_value = CREDIT_W'(COIN2_VAL);
            COIN_3:  o_value = CREDIT_W'(COIN3_VAL);
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/vending_credit.sv
// Three-coin credit accumulator with vend pulse and unit change train.
// Optional sales counter output enabled by defining VEND_COUNT_EN.
module vending_credit
    import vending_pkg::*;
#(
    parameter int PRICE       = 15,
    parameter int COIN1_VAL   = 5,
    parameter int COIN2_VAL   = 10,
    parameter int COIN3_VAL   = 25,
    parameter int CHANGE_UNIT = 5,
    parameter int CREDIT_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_coin,
    input  logic                i_cancel,
    output logic                o_vend,
    output logic                o_change_pulse,
    output logic                o_coin_reject,
    output logic                o_busy,
    output logic [CREDIT_W-1:0] o_credit,
`ifdef VEND_COUNT_EN
    output logic [15:0]         o_vend_count,
`endif
    output state_t              o_state
);

    if (!params_legal(PRICE, COIN1_VAL, COIN2_VAL, COIN3_VAL, CHANGE_UNIT, CREDIT_W))
    begin : g_param_check
        $error("vending_credit: illegal PRICE/COINn_VAL/CHANGE_UNIT/CREDIT_W combination");
    end

    localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] L_UNIT  = CREDIT_W'(CHANGE_UNIT);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_coin_reject;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;

    coin_value_dec #(
        .CREDIT_W  (CREDIT_W),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL),
        .COIN3_VAL (COIN3_VAL)
    ) u_coin_dec (
        .i_coin  (i_coin),
        .o_value (w_coin_val)
    );

    // Cannot overflow: legal parameters bound credit + coin below 2**CREDIT_W.
    assign w_sum = r_credit + w_coin_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    // Cancel wins over a completed price: a same-cycle coin is
                    // credited, then everything is refunded.
                    if (i_cancel) begin
                        r_credit <= w_sum;
                        r_state  <= (w_sum != '0) ? CHANGE : IDLE;
                    end else if (i_coin != COIN_NONE) begin
                        r_credit <= w_sum;
                        r_state  <= (w_sum >= L_PRICE) ? VEND : COLLECT;
                    end
                end
                VEND: begin
                    r_coin_reject <= (i_coin != COIN_NONE);
                    r_credit      <= r_credit - L_PRICE;
                    r_state       <= (r_credit == L_PRICE) ? IDLE : CHANGE;
                end
                CHANGE: begin
                    r_coin_reject <= (i_coin != COIN_NONE);
                    r_credit      <= r_credit - L_UNIT;
                    if (r_credit == L_UNIT) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_credit <= '0;
                end
            endcase
        end
    end

`ifdef VEND_COUNT_EN
    logic [15:0] r_vend_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vend_count <= '0;
        end else if ((r_state == VEND) && (r_vend_count != 16'hFFFF)) begin
            r_vend_count <= r_vend_count + 16'd1;
        end
    end

    assign o_vend_count = r_vend_count;
`endif

    assign o_vend         = (r_state == VEND);
    assign o_change_pulse = (r_state == CHANGE);
    assign o_busy         = (r_state == VEND) || (r_state == CHANGE);
    assign o_coin_reject  = r_coin_reject;
    assign o_credit       = r_credit;
    assign o_state        = r_state;

endmodule

// File: tb/tb_vending_credit.sv
// Directed and random stimulus for vending_credit against a schedule-based
// reference model; the sales counter is checked when VEND_COUNT_EN is defined.
module tb_vending_credit;
    import vending_pkg::*;

    localparam int PRICE = 15;
    localparam int C1    = 5;
    localparam int C2    = 10;
    localparam int C3    = 25;
    localparam int UNIT  = 5;
    localparam int W     = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   coin;
    logic         cancel;
    logic         vend;
    logic         change_pulse;
    logic         coin_reject;
    logic         busy;
    logic [W-1:0] credit;
    state_t       state;
`ifdef VEND_COUNT_EN
    logic [15:0]  vend_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vending_credit #(
        .PRICE       (PRICE),
        .COIN1_VAL   (C1),
        .COIN2_VAL   (C2),
        .COIN3_VAL   (C3),
        .CHANGE_UNIT (UNIT),
        .CREDIT_W    (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_coin         (coin),
        .i_cancel       (cancel),
        .o_vend         (vend),
        .o_change_pulse (change_pulse),
        .o_coin_reject  (coin_reject),
        .o_busy         (busy),
        .o_credit       (credit),
`ifdef VEND_COUNT_EN
        .o_vend_count   (vend_count),
`endif
        .o_state        (state)
    );

    // Reference model: while a sale or refund is in progress, the bench holds
    // the full list of upcoming busy cycles (one vend slot, then one slot per
    // change unit) and simply plays it out one entry per clock.
    typedef struct {
        bit is_vend;
        int credit;
    } slot_t;

    slot_t sched[$];
    int    m_credit;
    bit    m_reject;
    int    m_vends;

    function automatic int coin_val(input int c);
        case (c)
            1:       return C1;
            2:       return C2;
            3:       return C3;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        sched.delete();
        m_credit = 0;
        m_reject = 1'b0;
        m_vends  = 0;
    endtask

    task automatic push_refund(input int amount);
        slot_t s;
        for (int k = amount; k > 0; k -= UNIT) begin
            s.is_vend = 1'b0;
            s.credit  = k;
            sched.push_back(s);
        end
    endtask

    task automatic model_edge(input int c, input bit cx, input bit r);
        int    sum;
        slot_t s;
        if (r) begin
            model_reset();
        end else if (sched.size() > 0) begin
            if (sched[0].is_vend && (m_vends < 65535)) m_vends++;
            m_reject = (c != 0);
            void'(sched.pop_front());
        end else begin
            m_reject = 1'b0;
            sum = m_credit + coin_val(c);
            if (cx) begin
                m_credit = 0;
                push_refund(sum);
            end else if (c != 0) begin
                if (sum >= PRICE) begin
                    m_credit  = 0;
                    s.is_vend = 1'b1;
                    s.credit  = sum;
                    sched.push_back(s);
                    push_refund(sum - PRICE);
                end else begin
                    m_credit = sum;
                end
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int e_vend, e_chg, e_busy, e_credit, e_state;
        if (sched.size() > 0) begin
            e_vend   = sched[0].is_vend ? 1 : 0;
            e_chg    = sched[0].is_vend ? 0 : 1;
            e_busy   = 1;
            e_credit = sched[0].credit;
            e_state  = sched[0].is_vend ? int'(VEND) : int'(CHANGE);
        end else begin
            e_vend   = 0;
            e_chg    = 0;
            e_busy   = 0;
            e_credit = m_credit;
            e_state  = (m_credit == 0) ? int'(IDLE) : int'(COLLECT);
        end
        check("vend",         int'(vend),         e_vend);
        check("change_pulse", int'(change_pulse), e_chg);
        check("busy",         int'(busy),         e_busy);
        check("credit",       int'(credit),       e_credit);
        check("coin_reject",  int'(coin_reject),  int'(m_reject));
        check("state",        int'(state),        e_state);
`ifdef VEND_COUNT_EN
        check("vend_count",   int'(vend_count),   m_vends);
`endif
    endtask

    // One clock: check outputs mid-cycle, drive the inputs, advance the model
    // on the edge that samples them.
    task automatic cycle(input int c, input bit cx, input bit r);
        @(negedge clk);
        check_outputs();
        coin   = 2'(c);
        cancel = cx;
        rst    = r;
        @(posedge clk);
        model_edge(c, cx, r);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1'b0, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        coin   = 2'd0;
        cancel = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then three 5-unit coins make an exact sale.
        cycle(0, 1'b0, 1'b0);
        cycle(1, 1'b0, 1'b0);
        cycle(1, 1'b0, 1'b0);
        cycle(1, 1'b0, 1'b0);
        idle_cycles(3);

        // 25-unit coin: vend then two change pulses.
        cycle(3, 1'b0, 1'b0);
        idle_cycles(5);

        // 10 then cancel: full refund, no vend.
        cycle(2, 1'b0, 1'b0);
        cycle(0, 1'b1, 1'b0);
        idle_cycles(4);

        // Cancel in IDLE with no coin has no effect.
        cycle(0, 1'b1, 1'b0);
        idle_cycles(1);

        // Coin completing the price together with cancel refunds everything.
        cycle(1, 1'b0, 1'b0);
        cycle(2, 1'b1, 1'b0);
        idle_cycles(5);

        // Coin during the change phase is rejected and not credited.
        cycle(3, 1'b0, 1'b0);
        cycle(0, 1'b0, 1'b0);
        cycle(1, 1'b1, 1'b0);
        idle_cycles(4);

        // Reset in the first change cycle forfeits the rest.
        cycle(3, 1'b0, 1'b0);
        cycle(0, 1'b0, 1'b0);
        cycle(0, 1'b0, 1'b1);
        idle_cycles(3);

        // Three sales in a row for the counter, then reset clears it.
        for (int s = 0; s < 3; s++) begin
            cycle(2, 1'b0, 1'b0);
            cycle(1, 1'b0, 1'b0);
            idle_cycles(2);
        end
        cycle(0, 1'b0, 1'b1);
        idle_cycles(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int c;
            bit cx;
            bit r;
            c  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            cx = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 59) == 0);
            cycle(c, cx, r);
        end
        idle_cycles(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
